// File: rtl/xbus_arb.sv
// Data-memory bus arbiter: the CPU port always owns the bus; a single latched secondary
// request is served in the first cycle the CPU leaves the bus idle.
module xbus_arb #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_sel,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              per_req,
    input  logic              per_we,
    input  logic [ADDR_W-1:0] per_addr,
    input  logic [DATA_W-1:0] per_wdata,
    output logic              per_ack,
    output logic [DATA_W-1:0] per_rdata,
    output logic              busy,
    output logic              starve,
    output logic              mem_sel,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, PEND, ACK} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              hold_we;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_wdata;
    logic [CNT_W-1:0]  cnt;
    logic              grant;

    assign grant = (state == PEND) && !cpu_sel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (per_req) state_nxt = PEND;
            PEND:    if (!cpu_sel) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, starvation count and the registered completion side.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_we    <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            cnt        <= '0;
            per_ack    <= 1'b0;
            per_rdata  <= '0;
        end else begin
            per_ack <= grant;
            if (state == IDLE && per_req) begin
                hold_we    <= per_we;
                hold_addr  <= per_addr;
                hold_wdata <= per_wdata;
            end
            if (state == PEND) begin
                if (cpu_sel) begin
                    if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                end else begin
                    cnt <= '0;
                    if (!hold_we) per_rdata <= mem_rdata;
                end
            end
        end
    end

    // The CPU cannot stall, so it takes the bus whenever it asks, whatever the state.
    always_comb begin
        mem_sel   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (cpu_sel) begin
            mem_sel = 1'b1;
            mem_we  = cpu_we;
        end else if (state == PEND) begin
            mem_sel   = 1'b1;
            mem_we    = hold_we;
            mem_addr  = hold_addr;
            mem_wdata = hold_wdata;
        end
        busy      = (state != IDLE);
        starve    = (cnt == CNT_MAX);
        cpu_rdata = mem_rdata;
    end

endmodule

// File: tb/tb_xbus_arb.sv
// Testbench for xbus_arb: directed scenarios plus random traffic, checked against a
// transaction-level model of the arbitration rules and a scoreboard of pending acks.
module tb_xbus_arb;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 10;
    localparam int STARVE_MAX = 15;
    localparam int DEPTH      = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              cpu_sel;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              per_req;
    logic              per_we;
    logic [ADDR_W-1:0] per_addr;
    logic [DATA_W-1:0] per_wdata;
    logic              per_ack;
    logic [DATA_W-1:0] per_rdata;
    logic              busy;
    logic              starve;
    logic              mem_sel;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] env_mem [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one outstanding request, how long it has waited, and whether an ack is due.
    bit                m_pend;
    bit                m_ack;
    int                m_wait;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wd;
    logic [DATA_W-1:0] m_last_rd;
    logic [DATA_W-1:0] exp_q [$];

    xbus_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .cpu_sel(cpu_sel), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .per_req(per_req), .per_we(per_we), .per_addr(per_addr),
        .per_wdata(per_wdata), .per_ack(per_ack), .per_rdata(per_rdata),
        .busy(busy), .starve(starve),
        .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = env_mem[mem_addr];
    always @(posedge clk) if (mem_sel && mem_we) env_mem[mem_addr] <= mem_wdata;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pend    = 0;
            m_ack     = 0;
            m_wait    = 0;
            m_last_rd = '0;
            exp_q.delete();
        end else begin
            if (cpu_sel && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
            if (m_ack) begin
                m_ack = 0;
            end else if (m_pend) begin
                if (cpu_sel) begin
                    m_wait = (m_wait < STARVE_MAX) ? m_wait + 1 : STARVE_MAX;
                end else begin
                    if (m_we) ref_mem[m_addr] = m_wd;
                    else m_last_rd = ref_mem[m_addr];
                    exp_q.push_back(m_last_rd);
                    m_pend = 0;
                    m_wait = 0;
                    m_ack  = 1;
                end
            end else if (per_req) begin
                m_we   = per_we;
                m_addr = per_addr;
                m_wd   = per_wdata;
                m_pend = 1;
            end
        end
    end

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic check_output();
        logic              e_sel;
        logic              e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wd;
        logic [DATA_W-1:0] e_rd;
        e_sel  = 1'b0;
        e_we   = 1'b0;
        e_addr = cpu_addr;
        e_wd   = cpu_wdata;
        if (cpu_sel) begin
            e_sel = 1'b1;
            e_we  = cpu_we;
        end else if (m_pend) begin
            e_sel  = 1'b1;
            e_we   = m_we;
            e_addr = m_addr;
            e_wd   = m_wd;
        end
        check("mem_bus", 64'({mem_sel, mem_we, mem_addr, mem_wdata}), 64'({e_sel, e_we, e_addr, e_wd}));
        check("cpu_rdata", 64'(cpu_rdata), 64'(ref_mem[e_addr]));
        check("busy", 64'(busy), 64'(m_pend || m_ack));
        check("starve", 64'(starve), 64'(m_wait == STARVE_MAX));
        check("per_ack", 64'(per_ack), 64'(m_ack));
        if (per_ack) begin
            if (exp_q.size() == 0) begin
                check("ack_unexpected", 64'(1), 64'(0));
            end else begin
                e_rd = exp_q.pop_front();
                check("per_rdata", 64'(per_rdata), 64'(e_rd));
            end
        end
    endtask

    always @(negedge clk) if (rst) check_output();

    task automatic apply_stimulus(input logic c_sel, input logic c_we,
                                  input logic [ADDR_W-1:0] c_addr, input logic [DATA_W-1:0] c_wd,
                                  input logic p_req, input logic p_we,
                                  input logic [ADDR_W-1:0] p_addr, input logic [DATA_W-1:0] p_wd);
        cpu_sel   = c_sel;
        cpu_we    = c_we;
        cpu_addr  = c_addr;
        cpu_wdata = c_wd;
        per_req   = p_req;
        per_we    = p_we;
        per_addr  = p_addr;
        per_wdata = p_wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic cpu_cycles(input int n);
        for (int i = 0; i < n; i++)
            apply_stimulus(1, 0, ADDR_W'(i % 8), '0, 0, 0, '0, '0);
    endtask

    initial begin
        logic [DATA_W-1:0] v;
        int pct;
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            env_mem[i] = v;
            ref_mem[i] = v;
        end
        env_mem[10'h020] = 32'h1234;
        ref_mem[10'h020] = 32'h1234;

        rst = 1'b0;
        cpu_sel = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        per_req = 0; per_we = 0; per_addr = '0; per_wdata = '0;
        #2;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_ack", 64'(per_ack), 64'(0));
        check("reset_rdata", 64'(per_rdata), 64'(0));
        check("reset_starve", 64'(starve), 64'(0));
        check("reset_mem_sel", 64'(mem_sel), 64'(0));
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] idle-CPU write and read");
        apply_stimulus(0, 0, '0, '0, 1, 1, 10'h010, 32'hA5A5);
        idle_cycles(3);
        check("write_landed", 64'(env_mem[10'h010]), 64'(32'hA5A5));
        apply_stimulus(0, 0, '0, '0, 1, 0, 10'h020, '0);
        idle_cycles(3);

        $display("[TB] contention and starvation");
        apply_stimulus(0, 0, '0, '0, 1, 0, 10'h020, '0);
        cpu_cycles(5);
        idle_cycles(3);
        apply_stimulus(0, 0, '0, '0, 1, 1, 10'h030, 32'hCAFE);
        cpu_cycles(20);
        idle_cycles(3);

        $display("[TB] request held high");
        for (int i = 0; i < 9; i++) apply_stimulus(0, 0, '0, '0, 1, 0, ADDR_W'(i), '0);
        idle_cycles(3);

        $display("[TB] reset in PEND");
        apply_stimulus(0, 0, '0, '0, 1, 1, 10'h040, 32'hDEAD);
        cpu_cycles(2);
        cpu_sel = 1; cpu_we = 0;
        #1 rst = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ack", 64'(per_ack), 64'(0));
        check("rst_starve", 64'(starve), 64'(0));
        check("rst_rdata", 64'(per_rdata), 64'(0));
        check("rst_mem_sel_cpu", 64'(mem_sel), 64'(1));
        cpu_sel = 0;
        #1;
        check("rst_mem_sel_idle", 64'(mem_sel), 64'(0));
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        idle_cycles(4);

        $display("[TB] random traffic");
        pct = 10;
        for (int i = 0; i < 1600; i++) begin
            if (i % 200 == 0) begin
                case ($urandom_range(0, 3))
                    0: pct = 10;
                    1: pct = 50;
                    2: pct = 90;
                    default: pct = 100;
                endcase
            end
            apply_stimulus($urandom_range(0, 99) < pct, 1'($urandom), ADDR_W'($urandom_range(0, 15)), $urandom,
                           $urandom_range(0, 99) < 30, 1'($urandom), ADDR_W'($urandom_range(0, 15)), $urandom);
        end
        idle_cycles(5);
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
